// File: rtl/video_pkg.sv
// Shared video pipeline definitions: frame geometry defaults, pixel FIFO word
// layout and the framebuffer reader state encoding.
package video_pkg;

   localparam int HDISP_DEF = 800;
   localparam int VDISP_DEF = 480;
   localparam int PIX_W     = 32;

   typedef struct packed {
      logic             sof;
      logic [PIX_W-1:0] pix;
   } fifo_word_t;

   typedef enum logic [1:0] {IDLE, REQ, NEXT, WAIT} rd_state_t;

endpackage

// File: rtl/pixel_addr_gen.sv
// Raster pixel index counter for the framebuffer reader: wraps at the end of
// the frame and derives the byte address and start-of-frame flag.
module pixel_addr_gen #(
   parameter int          NPIX      = 800 * 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        advance,
   output logic [31:0] adr,
   output logic        sof,
   output logic        last
);

   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

   logic [IDX_W-1:0] idx_reg;
   logic [IDX_W-1:0] idx_next;
   logic [31:0]      offset;

   assign last   = (idx_reg == IDX_W'(NPIX - 1));
   assign sof    = (idx_reg == '0);
   assign offset = 32'(idx_reg) << 2;
   assign adr    = BASE_ADDR + offset;

   always_comb begin
      idx_next = idx_reg;
      if (advance) begin
         idx_next = last ? '0 : idx_reg + IDX_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         idx_reg <= '0;
      end else begin
         idx_reg <= idx_next;
      end
   end

endmodule

// File: rtl/frame_reader.sv
// Wishbone read master streaming the framebuffer from SDRAM into the pixel
// FIFO in raster order, one single-word read per pixel, looping over frames.
module frame_reader
   import video_pkg::*;
#(
   parameter int          HDISP     = HDISP_DEF,
   parameter int          VDISP     = VDISP_DEF,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             enable,
   output logic             wb_cyc,
   output logic             wb_stb,
   output logic             wb_we,
   output logic [31:0]      wb_adr,
   output logic [3:0]       wb_sel,
   input  logic             wb_ack,
   input  logic             wb_err,
   input  logic             wb_rty,
   input  logic [PIX_W-1:0] wb_dat_i,
   input  logic             fifo_afull,
   output logic             fifo_write,
   output logic [PIX_W:0]   fifo_wdata,
   output logic [7:0]       err_count
);

   rd_state_t  state_reg, state_next;
   fifo_word_t wdata_reg;
   logic       write_reg;
   logic [7:0] err_cnt_reg;
   logic       frame_done_reg;
   logic       in_req, ack_take, err_take, terminated;
   logic       pix_sof, pix_last;

   // ack outranks err, err outranks rty
   assign in_req     = (state_reg == REQ);
   assign ack_take   = in_req && wb_ack;
   assign err_take   = in_req && !wb_ack && wb_err;
   assign terminated = in_req && (wb_ack || wb_err || wb_rty);

   pixel_addr_gen #(
      .NPIX      (HDISP * VDISP),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .advance   (ack_take),
      .adr       (wb_adr),
      .sof       (pix_sof),
      .last      (pix_last)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_reg      <= IDLE;
         write_reg      <= 1'b0;
         wdata_reg      <= '0;
         err_cnt_reg    <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         write_reg <= ack_take;
         if (ack_take) begin
            wdata_reg <= '{sof: pix_sof, pix: wb_dat_i};
         end
         if (err_take && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
         // Only meaningful in NEXT: did the last termination close a frame?
         if (terminated) begin
            frame_done_reg <= ack_take && pix_last;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (enable && !fifo_afull) state_next = REQ;
         REQ:  if (terminated) state_next = NEXT;
         NEXT: begin
            if (frame_done_reg && !enable) state_next = IDLE;
            else if (fifo_afull)           state_next = WAIT;
            else                           state_next = REQ;
         end
         WAIT: if (!fifo_afull) state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   assign wb_cyc     = in_req;
   assign wb_stb     = in_req;
   assign wb_we      = 1'b0;
   assign wb_sel     = 4'hF;
   assign fifo_write = write_reg;
   assign fifo_wdata = wdata_reg;
   assign err_count  = err_cnt_reg;

endmodule
